// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - encodings shared by the stack sequencer and its arbiter
package stack_ctrl_pkg;

  localparam logic [7:0] SP_TOP_DEF      = 8'hFF;
  localparam int         STACK_DEPTH_DEF = 80;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_DEC  = 2'b01,
    SP_INC  = 2'b10,
    SP_LOAD = 2'b11
  } sp_rw_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PUSH,
    ST_POP_RD,
    ST_POP_DATA,
    ST_LOAD,
    ST_NOP
  } state_e;

endpackage

// File: rtl/stack_arb.sv
// rtl/stack_arb.sv - two-way fixed-priority arbiter, requester 1 wins, grant held until next pick
module stack_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_win,
  output logic [1:0] o_gnt
);

  logic [1:0] r_gnt;

  assign o_win = i_req[1] ? 2'b10 : (i_req[0] ? 2'b01 : 2'b00);
  assign o_gnt = r_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= 2'b00;
    end else if (i_en && (|i_req)) begin
      r_gnt <= o_win;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack pointer/RAM sequencer; STACK_CTRL_GUARD_EN enables overflow/underflow/bad-load guarding
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [7:0] SP_TOP      = SP_TOP_DEF,
  parameter int         STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [3:0]  op,
  input  logic [15:0] wdata,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic        err,
  input  logic        err_clr,
  output logic [6:0]  depth,
  output logic [1:0]  sp_rw,
  output logic [7:0]  sp_ld,
  input  logic [7:0]  sp_addr,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [7:0] SP_FLOOR  = SP_TOP - 8'(STACK_DEPTH);
  localparam logic [6:0] DEPTH_MAX = 7'(STACK_DEPTH);

  state_e     r_state;
  sp_rw_e     r_sp_rw;
  logic [1:0] r_ack;
  logic [7:0] r_rdata, r_sp_ld, r_mem_wdata, r_wd;
  logic [6:0] r_depth;
  logic       r_err, r_mem_we, r_mem_re;

  logic [1:0] w_win, w_gnt;
  op_e        w_op;
  logic [7:0] w_wd;
  logic       w_push_flt, w_pop_flt, w_load_flt, w_fault;

  stack_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == ST_IDLE),
    .i_req (req),
    .o_win (w_win),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_op = op_e'(op[1:0]);
    w_wd = wdata[7:0];
    if (w_win[1]) begin
      w_op = op_e'(op[3:2]);
      w_wd = wdata[15:8];
    end
  end

  assign w_push_flt = GUARD && (r_depth == DEPTH_MAX);
  assign w_pop_flt  = GUARD && (r_depth == 7'd0);
  assign w_load_flt = GUARD && (w_wd < SP_FLOOR);
  assign w_fault    = (r_state == ST_IDLE) && (|req) &&
                      (((w_op == OP_PUSH) && w_push_flt) ||
                       ((w_op == OP_POP)  && w_pop_flt)  ||
                       ((w_op == OP_LOAD) && w_load_flt));

  // Outputs are registered on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_sp_rw     <= SP_HOLD;
      r_ack       <= 2'b00;
      r_rdata     <= 8'h00;
      r_sp_ld     <= 8'h00;
      r_mem_wdata <= 8'h00;
      r_wd        <= 8'h00;
      r_depth     <= 7'd0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_ack    <= 2'b00;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_sp_rw  <= SP_HOLD;
      r_err    <= w_fault ? 1'b1 : (err_clr ? 1'b0 : r_err);
      case (r_state)
        ST_INIT: begin
          r_sp_rw <= SP_LOAD;
          r_sp_ld <= SP_TOP;
          r_depth <= 7'd0;
          r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (|req) begin
            r_wd    <= w_wd;
            r_ack   <= w_win;
            r_state <= ST_NOP;
            case (w_op)
              OP_PUSH: if (!w_push_flt) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_wd;
                r_sp_rw     <= SP_DEC;
                r_state     <= ST_PUSH;
              end
              OP_POP: if (w_pop_flt) begin
                r_rdata <= 8'h00;
              end else begin
                r_ack    <= 2'b00;
                r_sp_rw  <= SP_INC;
                r_mem_re <= 1'b1;
                r_state  <= ST_POP_RD;
              end
              OP_LOAD: if (!w_load_flt) begin
                r_sp_rw <= SP_LOAD;
                r_sp_ld <= w_wd;
                r_state <= ST_LOAD;
              end
              default: ;
            endcase
          end
        end
        ST_PUSH: begin
          r_depth <= r_depth + 7'd1;
          r_state <= ST_IDLE;
        end
        ST_POP_RD: begin
          r_depth <= r_depth - 7'd1;
          r_ack   <= w_gnt;
          r_state <= ST_POP_DATA;
        end
        ST_POP_DATA: begin
          r_rdata <= mem_rdata;
          r_state <= ST_IDLE;
        end
        ST_LOAD: begin
          r_depth <= 7'(SP_TOP - r_wd);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM data arrives during POP_DATA, so forward it while the ack is up.
  assign rdata     = (r_state == ST_POP_DATA) ? mem_rdata : r_rdata;
  assign ack       = r_ack;
  assign err       = r_err;
  assign depth     = r_depth;
  assign sp_rw     = r_sp_rw;
  assign sp_ld     = r_sp_ld;
  assign mem_addr  = sp_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl with pointer/RAM environment and reference model
module tb_stack_ctrl;

  localparam logic [7:0] TOP       = 8'hFF;
  localparam int         DEPTH_LIM = 80;
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  op;
  logic [15:0] wdata;
  logic        err_clr;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        err;
  logic [6:0]  depth;
  logic [1:0]  sp_rw;
  logic [7:0]  sp_ld;
  logic [7:0]  sp_addr;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .err_clr(err_clr), .depth(depth),
    .sp_rw(sp_rw), .sp_ld(sp_ld), .sp_addr(sp_addr), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Environment: unreset stack pointer and a one-cycle-latency RAM.
  logic [7:0] env_sp;
  logic [7:0] ram [256];
  assign sp_addr = sp_rw[1] ? env_sp + 8'd1 : env_sp;

  initial begin
    env_sp    <= 8'($urandom);
    mem_rdata <= 8'h00;
    for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h3C;
  end

  always @(posedge clk) begin
    case (sp_rw)
      2'b01:   env_sp <= env_sp - 8'd1;
      2'b10:   env_sp <= env_sp + 8'd1;
      2'b11:   env_sp <= sp_ld;
      default: ;
    endcase
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: a byte array addressed by a plain pointer.
  typedef struct {
    logic [1:0] ack;
    bit         is_pop;
    logic [7:0] rdata;
    bit         we;
    logic [7:0] waddr;
    logic [7:0] wdat;
    logic [1:0] sprw;
    logic [6:0] depth;
    bit         err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  int         m_depth;
  bit         m_err;

  task automatic model_reset();
    m_sp = TOP; m_depth = 0; m_err = 0;
  endtask

  task automatic model_op(input logic [1:0] who, input logic [1:0] o, input logic [7:0] wd, input bit clr);
    exp_t e;
    bit   fault;
    fault = 0;
    e.ack = who; e.is_pop = (o == 2'b10); e.rdata = 8'h00; e.we = 0;
    e.waddr = 8'h00; e.wdat = 8'h00; e.sprw = 2'b00;
    case (o)
      2'b01: if (GUARD && m_depth == DEPTH_LIM) fault = 1;
             else begin
               e.we = 1; e.waddr = m_sp; e.wdat = wd; e.sprw = 2'b01;
               m_mem[m_sp] = wd; m_sp = m_sp - 8'd1; m_depth = (m_depth + 1) % 128;
             end
      2'b10: if (GUARD && m_depth == 0) fault = 1;
             else begin
               m_sp = m_sp + 8'd1; e.rdata = m_mem[m_sp]; m_depth = (m_depth + 127) % 128;
             end
      2'b11: if (GUARD && int'(wd) < int'(TOP) - DEPTH_LIM) fault = 1;
             else begin
               m_sp = wd; m_depth = (int'(TOP) - int'(wd)) % 128; e.sprw = 2'b11;
             end
      default: ;
    endcase
    if (fault) m_err = 1;
    else if (clr) m_err = 0;
    e.depth = 7'(m_depth);
    e.err   = m_err;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation for every ack the DUT presents.
  exp_t       mon_e;
  logic [6:0] dexp;
  bit         dpend = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dpend = 0;
    end else begin
      if (dpend) begin
        chk("depth_after_op", 16'(depth), 16'(dexp));
        dpend = 0;
      end
      if (ack != 2'b00) begin
        if (q.size() == 0) begin
          chk("spurious_ack", 16'(ack), 16'h0);
        end else begin
          mon_e = q.pop_front();
          chk("ack_owner", 16'(ack), 16'(mon_e.ack));
          chk("mem_we", 16'(mem_we), 16'(mon_e.we));
          if (mon_e.we) begin
            chk("write_addr", 16'(mem_addr), 16'(mon_e.waddr));
            chk("write_data", 16'(mem_wdata), 16'(mon_e.wdat));
          end
          chk("sp_rw_at_ack", 16'(sp_rw), 16'(mon_e.sprw));
          if (mon_e.is_pop) chk("pop_rdata", 16'(rdata), 16'(mon_e.rdata));
          chk("err", 16'(err), 16'(mon_e.err));
          dexp  = mon_e.depth;
          dpend = 1;
        end
      end else if (mem_we) begin
        chk("write_without_ack", 16'(mem_we), 16'h0);
      end
    end
  end

  task automatic batch(input logic [1:0] who, input logic [1:0] o1, input logic [1:0] o0,
                       input logic [7:0] w1, input logic [7:0] w0, input bit clr);
    int         cyc;
    logic [1:0] pend;
    if (who[1]) model_op(2'b10, o1, w1, clr);
    if (who[0]) model_op(2'b01, o0, w0, clr);
    op = {o1, o0}; wdata = {w1, w0}; err_clr = clr; req = who;
    pend = who; cyc = 0;
    while (pend != 2'b00 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      pend = pend & ~ack;
      req  = req & ~ack;
      if (ack != 2'b00) err_clr = 1'b0;
    end
    if (pend != 2'b00) begin
      chk("ack_timeout", 16'(pend), 16'h0);
      req = 2'b00; err_clr = 1'b0;
    end
  endtask

  task automatic init_check(input string tag);
    int loads, acks;
    loads = 0; acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (sp_rw == 2'b11 && sp_ld == TOP) loads++;
      if (ack != 2'b00) acks++;
    end
    chk({tag, "_init_load_cycles"}, 16'(loads), 16'd1);
    chk({tag, "_init_acks"}, 16'(acks), 16'd0);
    chk({tag, "_init_depth"}, 16'(depth), 16'd0);
  endtask

  function automatic logic [7:0] rand_wd(input logic [1:0] o);
    if (o == 2'b11 && $urandom_range(0, 3) != 0) return 8'($urandom_range(175, 255));
    return 8'($urandom);
  endfunction

  initial begin
    int         cyc, quiet;
    logic [1:0] who, o1, o0;
    req = 2'b00; op = 4'h0; wdata = 16'h0; err_clr = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ack", 16'(ack), 16'h0);
    chk("rst_sp_rw", 16'(sp_rw), 16'h0);
    chk("rst_sp_ld", 16'(sp_ld), 16'h0);
    chk("rst_depth", 16'(depth), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_strobes", {14'h0, mem_we, mem_re}, 16'h0);
    chk("rst_rdata", 16'(rdata), 16'h0);
    rst_n = 1'b1;
    init_check("first");

    batch(2'b01, 2'b00, 2'b01, 8'h00, 8'hA5, 0);
    batch(2'b01, 2'b00, 2'b10, 8'h00, 8'h00, 0);
    batch(2'b11, 2'b01, 2'b01, 8'h11, 8'h22, 0);
    batch(2'b11, 2'b10, 2'b10, 8'h00, 8'h00, 0);

    batch(2'b01, 2'b00, 2'b10, 8'h00, 8'h00, 0);
    batch(2'b10, 2'b01, 2'b00, 8'h00, 8'h00, 0);
    batch(2'b10, 2'b10, 2'b00, 8'h00, 8'h00, 0);
    batch(2'b01, 2'b00, 2'b11, 8'h00, 8'hFF, 0);
    for (int i = 0; i < DEPTH_LIM + 1; i++) batch(2'b01, 2'b00, 2'b01, 8'h00, 8'(i + 3), 0);

    batch(2'b01, 2'b00, 2'b11, 8'h00, 8'hA0, 0);
    batch(2'b01, 2'b00, 2'b11, 8'h00, 8'hF0, 0);
    batch(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    batch(2'b01, 2'b00, 2'b11, 8'h00, 8'hA0, 1);
    batch(2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 1);

    repeat (250) begin
      who = 2'($urandom_range(1, 3));
      o1  = 2'($urandom_range(0, 3));
      o0  = 2'($urandom_range(0, 3));
      batch(who, o1, o0, rand_wd(o1), rand_wd(o0), 0);
    end

    batch(2'b01, 2'b00, 2'b11, 8'h00, 8'hF0, 0);
    req = 2'b01; op = 4'b0010; wdata = 16'h0;
    cyc = 0;
    while (!mem_re && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("pop_rd_reached", 16'(mem_re), 16'h1);
    rst_n = 1'b0; req = 2'b00;
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != 2'b00 || mem_we) quiet++;
    end
    chk("reset_abort_quiet", 16'(quiet), 16'h0);
    q.delete();
    model_reset();
    rst_n = 1'b1;
    init_check("midop");
    batch(2'b01, 2'b00, 2'b01, 8'h00, 8'h5C, 0);
    batch(2'b01, 2'b00, 2'b10, 8'h00, 8'h00, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
